if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined CPU.
- Holds the PC and drives the instruction-memory address.
- Captures the fetched instruction into IF/ID and decodes the rs/rt/rd fields that feed the hazard unit.
- Consumes the hazard unit's stall and the EX-stage branch redirect.

Parameters:
- PC_WIDTH, 16, PC and instruction-address width (word-addressed).
- INSTR_WIDTH, 16, instruction width.
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INSTR, 16'h0000, encoding loaded into IF/ID on a bubble.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  load-use stall from the hazard unit; hold PC and IF/ID.
- branch_taken  in  1  redirect from EX; flush IF/ID.
- branch_target  in  PC_WIDTH  redirect PC.
- imem_addr  out  PC_WIDTH  equals pc (combinational).
- imem_rdata  in  INSTR_WIDTH  asynchronous instruction-ROM data for imem_addr.
- imem_valid  in  1  imem_rdata is usable this cycle.
- pc  out  PC_WIDTH  current fetch PC.
- if_id_instr  out  INSTR_WIDTH  registered instruction.
- if_id_pc  out  PC_WIDTH  PC of if_id_instr.
- if_id_pc_plus1  out  PC_WIDTH  if_id_pc+1, for link/branch-offset use.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_rd  out  4  if_id_instr[11:8].
- if_id_rs  out  4  if_id_instr[7:4].
- if_id_rt  out  4  if_id_instr[3:0].

Behaviour:
- Instruction format: opcode[15:12], rd[11:8], rs[7:4], rt[3:0]. rd/rs/rt outputs are combinational slices of the IF/ID register.
- Each cycle is evaluated in strict priority order:
  1. reset: pc<=RESET_PC; if_id_instr<=NOP_INSTR; if_id_pc<=0; if_id_pc_plus1<=0; if_id_valid<=0.
  2. branch_taken: pc<=branch_target; IF/ID<=bubble (NOP_INSTR, valid=0, pc fields 0). Overrides stall: the stalled ID instruction is younger than the branch and is discarded.
  3. stall: pc and all IF/ID fields hold their values; imem_rdata is ignored.
  4. !imem_valid: pc holds; IF/ID<=bubble.
  5. Otherwise: if_id_instr<=imem_rdata; if_id_pc<=pc; if_id_pc_plus1<=pc+1; if_id_valid<=1; pc<=pc+1.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH, so 16'hFFFF wraps to 16'h0000 with no flag.
- Latency:
  - Instruction at PC n appears on if_id_instr one cycle after pc==n with imem_valid=1 and no stall/redirect.
  - A redirect asserted in cycle t gives pc==branch_target in t+1 and the target instruction in IF/ID in t+2.
- Bubble encoding: rs=rt=rd=0. The hazard unit's rd!=0 check prevents false forwarding; a load to r0 never reaches the hazard unit as a real stall source.
- Reset mid-stall or mid-redirect: reset wins; the next cycle fetches RESET_PC.
- A stall lasting N cycles holds state for exactly N cycles, with no replay or skipped PC.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cycles[15:0] and flush_count[15:0].
  - stall_cycles increments on any cycle with stall && !branch_taken && !reset.
  - flush_count increments on any cycle with branch_taken && !reset.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - Field-position constants OPC_HI/LO, RD_HI/LO, RS_HI/LO, RT_HI/LO.
  - NOP encoding.
  - Register-ID width (4).
  - PC/instruction widths.
- One natural sub-module, pc_reg: PC register with reset/redirect/hold/increment priority.
- The IF/ID register and field decode stay in if_stage.

Test Plan:
- Reset, then imem_valid=1 with imem_rdata=16'h1234 at pc 0: next cycle if_id_instr=16'h1234, if_id_pc=0, if_id_pc_plus1=1, if_id_valid=1, pc=1, rd=2, rs=3, rt=4.
- stall held 3 cycles at pc=5 with IF/ID=16'hA123: pc stays 5 and IF/ID stays 16'hA123 for all 3 cycles; the instruction at pc 5 is captured in the cycle after stall drops.
- branch_taken=1 and stall=1 together with branch_target=16'h0040: next cycle pc=16'h0040, if_id_valid=0, if_id_instr=16'h0000.
- imem_valid=0 for 2 cycles at pc=9: pc holds 9, IF/ID is a bubble both cycles; imem_valid=1 then loads the pc 9 instruction.
- pc=16'hFFFF with normal fetch: pc becomes 16'h0000 and if_id_pc=16'hFFFF, if_id_pc_plus1=16'h0000.
- Reset asserted during a stall at pc=7: next cycle pc=RESET_PC, if_id_valid=0. With IF_STAGE_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU.
// Holds instruction field positions, widths and the NOP encoding.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int REG_W   = 4;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 0;

    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    typedef logic [REG_W-1:0] reg_id_t;

endpackage

// File: rtl/if_stage_pc_reg.sv
// pc_reg: fetch PC register, priority reset > redirect > hold > increment.
// Ports: clk, reset, redirect, target, hold -> pc (wraps modulo 2^W).
module pc_reg
    import cpu_pkg::*;
#(
    parameter int           W         = PC_W,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect,
    input  logic [W-1:0] target,
    input  logic         hold,
    output logic [W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_VAL;
        else if (redirect)
            pc <= target;
        else if (!hold)
            pc <= pc + W'(1);
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch plus IF/ID register and rd/rs/rt decode.
// Ports: clk, reset, stall, branch_taken/target, imem_* -> pc, if_id_*.
// Optional IF_STAGE_PERF_CNT_EN adds stall_cycles and flush_count.
module if_stage
    import cpu_pkg::*;
#(
    parameter int                     PC_WIDTH    = PC_W,
    parameter int                     INSTR_WIDTH = INSTR_W,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = NOP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic [PC_WIDTH-1:0]    if_id_pc_plus1,
    output logic                   if_id_valid,
    output logic [REG_W-1:0]       if_id_rd,
    output logic [REG_W-1:0]       if_id_rs,
    output logic [REG_W-1:0]       if_id_rt
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [15:0]            stall_cycles,
    output logic [15:0]            flush_count
`endif
);

    // PC holds on stall and while the ROM has nothing usable.
    logic pc_hold;
    assign pc_hold = stall || !imem_valid;

    pc_reg #(
        .W         (PC_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .redirect (branch_taken),
        .target   (branch_target),
        .hold     (pc_hold),
        .pc       (pc)
    );

    assign imem_addr = pc;

    // Redirect beats stall: the held ID instruction is wrong-path.
    always_ff @(posedge clk) begin
        if (reset || branch_taken) begin
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            if (imem_valid) begin
                if_id_instr    <= imem_rdata;
                if_id_pc       <= pc;
                if_id_pc_plus1 <= pc + PC_WIDTH'(1);
                if_id_valid    <= 1'b1;
            end else begin
                if_id_instr    <= NOP_INSTR;
                if_id_pc       <= '0;
                if_id_pc_plus1 <= '0;
                if_id_valid    <= 1'b0;
            end
        end
    end

    assign if_id_rd = if_id_instr[RD_HI:RD_LO];
    assign if_id_rs = if_id_instr[RS_HI:RS_LO];
    assign if_id_rt = if_id_instr[RT_HI:RT_LO];

`ifdef IF_STAGE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (branch_taken && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
            if (stall && !branch_taken && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus random checks of if_stage.
// Compares every cycle against a behavioural fetch model.
module tb_if_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic [3:0]  if_id_rd;
    logic [3:0]  if_id_rs;
    logic [3:0]  if_id_rt;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic [15:0] m_ipc1;
    logic        m_valid;
    int          m_stalls;
    int          m_flushes;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_valid     (imem_valid),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .if_id_rd       (if_id_rd),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic bubble();
        m_instr = 16'h0000;
        m_ipc   = 16'h0000;
        m_ipc1  = 16'h0000;
        m_valid = 1'b0;
    endtask

    task automatic model(input logic r, input logic s, input logic b,
                         input logic [15:0] t, input logic iv,
                         input logic [15:0] d);
        if (r) begin
            m_pc = 16'h0000;
            bubble();
            m_stalls = 0;
            m_flushes = 0;
        end else if (b) begin
            m_pc = t;
            bubble();
            m_flushes++;
        end else if (s) begin
            m_stalls++;
        end else if (!iv) begin
            bubble();
        end else begin
            m_instr = d;
            m_ipc   = m_pc;
            m_ipc1  = m_pc + 16'd1;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
        end
    endtask

    task automatic check_all();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("instr", 32'(if_id_instr), 32'(m_instr));
        chk("if_id_pc", 32'(if_id_pc), 32'(m_ipc));
        chk("pc_plus1", 32'(if_id_pc_plus1), 32'(m_ipc1));
        chk("valid", 32'(if_id_valid), 32'(m_valid));
        chk("rd", 32'(if_id_rd), 32'((m_instr >> 8) & 16'hF));
        chk("rs", 32'(if_id_rs), 32'((m_instr >> 4) & 16'hF));
        chk("rt", 32'(if_id_rt), 32'(m_instr & 16'hF));
`ifdef IF_STAGE_PERF_CNT_EN
        chk("stall_cycles", 32'(stall_cycles),
            32'((m_stalls > 65535) ? 65535 : m_stalls));
        chk("flush_count", 32'(flush_count),
            32'((m_flushes > 65535) ? 65535 : m_flushes));
`endif
    endtask

    task automatic step(input logic r, input logic s, input logic b,
                        input logic [15:0] t, input logic iv,
                        input logic [15:0] d);
        reset         = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        imem_valid    = iv;
        imem_rdata    = d;
        @(posedge clk);
        #1;
        model(r, s, b, t, iv, d);
        check_all();
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        m_pc = 16'h0000;
        bubble();
        m_stalls = 0;
        m_flushes = 0;

        step(1, 0, 0, 16'h0000, 0, 16'h0000);
        step(1, 1, 1, 16'h5555, 1, 16'hFFFF);
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_valid", 32'(if_id_valid), 32'h0);

        step(0, 0, 0, 16'h0000, 1, 16'h1234);
        chk("t1_instr", 32'(if_id_instr), 32'h1234);
        chk("t1_pc", 32'(pc), 32'h1);
        chk("t1_rd", 32'(if_id_rd), 32'h2);
        chk("t1_rs", 32'(if_id_rs), 32'h3);
        chk("t1_rt", 32'(if_id_rt), 32'h4);
        chk("t1_pc1", 32'(if_id_pc_plus1), 32'h1);

        repeat (3) step(0, 0, 0, 16'h0000, 1, 16'($urandom));
        step(0, 0, 0, 16'h0000, 1, 16'hA123);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 16'h0000, 1, 16'($urandom));
            chk("stall_pc", 32'(pc), 32'h5);
            chk("stall_instr", 32'(if_id_instr), 32'hA123);
        end
        step(0, 0, 0, 16'h0000, 1, 16'hBEEF);
        chk("unstall_ipc", 32'(if_id_pc), 32'h5);
        chk("unstall_instr", 32'(if_id_instr), 32'hBEEF);

        step(0, 1, 1, 16'h0040, 1, 16'h9999);
        chk("br_pc", 32'(pc), 32'h40);
        chk("br_valid", 32'(if_id_valid), 32'h0);
        chk("br_instr", 32'(if_id_instr), 32'h0);
        step(0, 0, 0, 16'h0000, 1, 16'h4321);
        chk("br_target_instr", 32'(if_id_instr), 32'h4321);
        chk("br_target_ipc", 32'(if_id_pc), 32'h40);

        step(0, 0, 1, 16'h0009, 1, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 16'h0000, 0, 16'($urandom));
            chk("inv_pc", 32'(pc), 32'h9);
            chk("inv_valid", 32'(if_id_valid), 32'h0);
        end
        step(0, 0, 0, 16'h0000, 1, 16'h7777);
        chk("inv_ipc", 32'(if_id_pc), 32'h9);
        chk("inv_instr", 32'(if_id_instr), 32'h7777);

        step(0, 0, 1, 16'hFFFF, 1, 16'h0000);
        step(0, 0, 0, 16'h0000, 1, 16'h1111);
        chk("wrap_pc", 32'(pc), 32'h0);
        chk("wrap_ipc", 32'(if_id_pc), 32'hFFFF);
        chk("wrap_pc1", 32'(if_id_pc_plus1), 32'h0);

        step(0, 0, 1, 16'h0007, 1, 16'h0000);
        step(0, 1, 0, 16'h0000, 1, 16'h2222);
        step(1, 1, 0, 16'h0000, 1, 16'h3333);
        chk("rst_stall_pc", 32'(pc), 32'h0);
        chk("rst_stall_valid", 32'(if_id_valid), 32'h0);
`ifdef IF_STAGE_PERF_CNT_EN
        chk("rst_stall_cyc", 32'(stall_cycles), 32'h0);
        chk("rst_flush_cnt", 32'(flush_count), 32'h0);
`endif
        step(0, 0, 0, 16'h0000, 1, 16'h4444);
        chk("rst_refetch_ipc", 32'(if_id_pc), 32'h0);

        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(99) < 2),
                 logic'($urandom_range(99) < 25),
                 logic'($urandom_range(99) < 10),
                 16'($urandom),
                 logic'($urandom_range(99) < 80),
                 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
